// File: rtl/j1_code_loader.sv
// Boot loader for the j1 core: receives a framed program image over a byte stream,
// writes it into the 8K x 16 code RAM, and then releases the core from reset.
// When J1_LOADER_RELOAD_EN is defined, a new frame can also be accepted while the core is running.
module j1_code_loader #(
    parameter int ADDR_W      = 13,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic              clk,
    input  logic              resetq,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [ADDR_W-1:0] code_addr,
    output logic [15:0]       insn,
    output logic              core_reset,
    output logic              load_done,
    output logic              load_err
);

    localparam int              DEPTH    = 1 << ADDR_W;
    localparam logic [16:0]     LEN_MAX  = 17'(DEPTH);
    localparam int              TMO_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [7:0]      MAGIC    = 8'hA5;

    typedef enum logic [2:0] {
        S_WAIT_MAGIC = 3'd0,
        S_LEN_HI     = 3'd1,
        S_LEN_LO     = 3'd2,
        S_DATA_LO    = 3'd3,
        S_DATA_HI    = 3'd4,
        S_CHECK      = 3'd5,
        S_RUN        = 3'd6,
        S_ERROR      = 3'd7
    } state_t;

    state_t           r_state;
    logic [15:0]      r_len;
    logic [16:0]      r_idx;
    logic [7:0]       r_csum;
    logic [7:0]       r_lo;
    logic [TMO_W-1:0] r_tmo;
    logic             r_core_reset;
    logic             r_load_done;
    logic             r_load_err;
    logic [15:0]      r_insn;
    logic [15:0]      r_mem [0:DEPTH-1];

    logic             w_acc;
    logic             w_we;
    logic [15:0]      w_len_next;
    logic             w_len_big;
    logic             w_last;

`ifdef J1_LOADER_RELOAD_EN
    assign rx_ready = (r_state != S_ERROR);
`else
    assign rx_ready = (r_state != S_RUN) && (r_state != S_ERROR);
`endif

    assign w_acc      = rx_valid && rx_ready;
    assign w_we       = w_acc && (r_state == S_DATA_HI);
    assign w_len_next = {r_len[15:8], rx_data};
    assign w_len_big  = ({1'b0, w_len_next} > LEN_MAX);
    assign w_last     = ((r_idx + 17'd1) == {1'b0, r_len});

    assign insn       = r_insn;
    assign core_reset = r_core_reset;
    assign load_done  = r_load_done;
    assign load_err   = r_load_err;

    // Code RAM write port (loader side); no reset so the image survives resetq.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_mem[r_idx[ADDR_W-1:0]] <= {rx_data, r_lo};
        end
    end

    // Core fetch port: registered read, old data on a same-address write.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_insn <= 16'h0000;
        end else begin
            r_insn <= r_mem[code_addr];
        end
    end

    // Frame parser, checksum, inter-byte timeout and core reset control.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            r_state      <= S_WAIT_MAGIC;
            r_len        <= 16'h0000;
            r_idx        <= 17'd0;
            r_csum       <= 8'h00;
            r_lo         <= 8'h00;
            r_tmo        <= '0;
            r_core_reset <= 1'b1;
            r_load_done  <= 1'b0;
            r_load_err   <= 1'b0;
        end else begin
            case (r_state)
                S_WAIT_MAGIC: begin
                    r_tmo <= '0;
                    if (w_acc && (rx_data == MAGIC)) begin
                        r_load_err <= 1'b0;
                        r_csum     <= 8'h00;
                        r_state    <= S_LEN_HI;
                    end
                end
                S_RUN: begin
`ifdef J1_LOADER_RELOAD_EN
                    if (w_acc && (rx_data == MAGIC)) begin
                        r_core_reset <= 1'b1;
                        r_load_done  <= 1'b0;
                        r_load_err   <= 1'b0;
                        r_csum       <= 8'h00;
                        r_tmo        <= '0;
                        r_state      <= S_LEN_HI;
                    end
`else
                    r_state <= S_RUN;
`endif
                end
                S_ERROR: begin
                    r_load_err <= 1'b1;
                    r_tmo      <= '0;
                    r_state    <= S_WAIT_MAGIC;
                end
                S_LEN_HI, S_LEN_LO, S_DATA_LO, S_DATA_HI, S_CHECK: begin
                    if (w_acc) begin
                        r_tmo <= '0;
                        case (r_state)
                            S_LEN_HI: begin
                                r_len[15:8] <= rx_data;
                                r_csum      <= r_csum ^ rx_data;
                                r_state     <= S_LEN_LO;
                            end
                            S_LEN_LO: begin
                                r_len[7:0] <= rx_data;
                                r_csum     <= r_csum ^ rx_data;
                                r_idx      <= 17'd0;
                                if (w_len_big) begin
                                    r_state <= S_ERROR;
                                end else if (w_len_next == 16'h0000) begin
                                    r_state <= S_CHECK;
                                end else begin
                                    r_state <= S_DATA_LO;
                                end
                            end
                            S_DATA_LO: begin
                                r_lo    <= rx_data;
                                r_csum  <= r_csum ^ rx_data;
                                r_state <= S_DATA_HI;
                            end
                            S_DATA_HI: begin
                                r_csum  <= r_csum ^ rx_data;
                                r_idx   <= r_idx + 17'd1;
                                r_state <= w_last ? S_CHECK : S_DATA_LO;
                            end
                            S_CHECK: begin
                                if (rx_data == r_csum) begin
                                    r_core_reset <= 1'b0;
                                    r_load_done  <= 1'b1;
                                    r_state      <= S_RUN;
                                end else begin
                                    r_state <= S_ERROR;
                                end
                            end
                            default: r_state <= S_ERROR;
                        endcase
                    end else if (r_tmo == TMO_LAST) begin
                        r_tmo   <= '0;
                        r_state <= S_ERROR;
                    end else begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                default: r_state <= S_WAIT_MAGIC;
            endcase
        end
    end

endmodule

// File: tb/tb_j1_code_loader.sv
// Self-checking bench for j1_code_loader: a byte-position model of the frame rules,
// compared against the DUT every cycle, plus literal expectations for each scenario.
`timescale 1ns/1ps
module tb_j1_code_loader;

    localparam int ADDR_W = 13;
    localparam int TMO    = 16;
    localparam int DEPTH  = 1 << ADDR_W;
`ifdef J1_LOADER_RELOAD_EN
    localparam bit RELOAD = 1'b1;
`else
    localparam bit RELOAD = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              resetq = 1'b1;
    logic [7:0]        rx_data = 8'h00;
    logic              rx_valid = 1'b0;
    logic              rx_ready;
    logic [ADDR_W-1:0] code_addr = 13'd1;
    logic [15:0]       insn;
    logic              core_reset;
    logic              load_done;
    logic              load_err;

    int n_chk  = 0;
    int n_fail = 0;

    j1_code_loader #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TMO)) dut (
        .clk(clk), .resetq(resetq), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .code_addr(code_addr), .insn(insn),
        .core_reset(core_reset), .load_done(load_done), .load_err(load_err)
    );

    always #5 clk = ~clk;

    // Model state: position of the next expected byte inside the frame (0 = magic).
    int          m_pos = 0, m_len = 0, m_idle = 0, n_acc = 0;
    logic [7:0]  m_csum = 8'h00, m_lo = 8'h00;
    logic        m_run = 1'b0, m_errcyc = 1'b0, m_err = 1'b0;
    logic [15:0] m_insn = 16'h0000;
    logic        m_insn_known = 1'b1;
    logic [15:0] m_mem [0:DEPTH-1];
    bit          m_known [0:DEPTH-1];

    function automatic logic m_ready();
        return !m_errcyc && (!m_run || RELOAD);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference behaviour evaluated on each clock edge.
    always @(posedge clk or negedge resetq) begin
        logic acc;
        logic bad;
        if (!resetq) begin
            m_pos = 0; m_len = 0; m_idle = 0; m_csum = 8'h00; m_lo = 8'h00;
            m_run = 1'b0; m_errcyc = 1'b0; m_err = 1'b0;
            m_insn = 16'h0000; m_insn_known = 1'b1;
        end else begin
            acc = rx_valid && m_ready();
            bad = 1'b0;
            m_insn = m_mem[code_addr];
            m_insn_known = m_known[code_addr];
            if (acc) n_acc++;
            if (m_errcyc) begin
                m_errcyc = 1'b0; m_err = 1'b1; m_pos = 0;
            end else if (m_pos == 0) begin
                if (acc && rx_data == 8'hA5) begin
                    m_run = 1'b0; m_err = 1'b0; m_csum = 8'h00; m_idle = 0; m_pos = 1;
                end
            end else if (acc) begin
                m_idle = 0;
                if (m_pos == 1) begin
                    m_len = int'(rx_data) * 256; m_csum ^= rx_data; m_pos = 2;
                end else if (m_pos == 2) begin
                    m_len += int'(rx_data); m_csum ^= rx_data; m_pos = 3;
                    if (m_len > DEPTH) bad = 1'b1;
                end else if (m_pos < 3 + 2 * m_len) begin
                    m_csum ^= rx_data;
                    if ((m_pos - 3) % 2 == 0) m_lo = rx_data;
                    else begin
                        m_mem[(m_pos - 3) / 2] = {rx_data, m_lo};
                        m_known[(m_pos - 3) / 2] = 1'b1;
                    end
                    m_pos++;
                end else if (rx_data == m_csum) begin
                    m_run = 1'b1; m_pos = 0;
                end else begin
                    bad = 1'b1;
                end
            end else begin
                m_idle++;
                if (m_idle == TMO) bad = 1'b1;
            end
            if (bad) begin
                m_errcyc = 1'b1; m_pos = 0; m_idle = 0;
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        chk("rx_ready", 32'(rx_ready), 32'(m_ready()));
        chk("core_reset", 32'(core_reset), 32'(!m_run));
        chk("load_done", 32'(load_done), 32'(m_run));
        chk("load_err", 32'(load_err), 32'(m_err));
        if (m_insn_known) chk("insn", 32'(insn), 32'(m_insn));
    end

    task automatic send(input logic [7:0] b, input int gap);
        bit got = 1'b0;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_valid = 1'b1;
        rx_data  = b;
        for (int i = 0; i < 64 && !got; i++) begin
            if (rx_ready) got = 1'b1;
            @(negedge clk);
        end
        rx_valid = 1'b0;
        n_chk++;
        if (!got) begin
            n_fail++;
            $display("FAIL accept_timeout: byte 0x%0h not accepted within 64 cycles", b);
        end
    endtask

    task automatic send_seq(input logic [7:0] seq [], input int max_gap);
        foreach (seq[i]) send(seq[i], $urandom_range(max_gap, 0));
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 resetq = 1'b0;
        @(negedge clk);
        #2 resetq = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        rx_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0;
        #1 resetq = 1'b0;
        #21 resetq = 1'b1;
        @(negedge clk);
        chk("rst_core_reset", 32'(core_reset), 32'd1);
        chk("rst_load_done", 32'(load_done), 32'd0);
        chk("rst_load_err", 32'(load_err), 32'd0);
        chk("rst_insn", 32'(insn), 32'h0);
        chk("rst_rx_ready", 32'(rx_ready), 32'd1);

        // Two-word image; checksum 00^02^34^12^78^56 = 0x0A.
        send_seq('{8'hA5, 8'h00, 8'h02, 8'h34, 8'h12, 8'h78, 8'h56, 8'h0A}, 0);
        chk("a_core_reset", 32'(core_reset), 32'd0);
        chk("a_load_done", 32'(load_done), 32'd1);
        @(negedge clk);
        chk("a_insn1", 32'(insn), 32'h5678);
        code_addr = 13'd0;
        @(negedge clk);
        chk("a_insn0", 32'(insn), 32'h1234);
        chk("a_rx_ready_run", 32'(rx_ready), 32'(RELOAD));

        // Noise bytes then an empty image.
        do_reset();
        send_seq('{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00}, 1);
        chk("z_load_done", 32'(load_done), 32'd1);
        chk("z_core_reset", 32'(core_reset), 32'd0);

        // Bad checksum, then the same frame with the right one (0x67).
        do_reset();
        send_seq('{8'hA5, 8'h00, 8'h01, 8'hCD, 8'hAB, 8'h00}, 0);
        chk("e_rx_ready_err", 32'(rx_ready), 32'd0);
        chk("e_core_reset", 32'(core_reset), 32'd1);
        @(negedge clk);
        chk("e_load_err", 32'(load_err), 32'd1);
        chk("e_rx_ready_back", 32'(rx_ready), 32'd1);
        send(8'hA5, 0);
        chk("e_err_cleared", 32'(load_err), 32'd0);
        send_seq('{8'h00, 8'h01, 8'hCD, 8'hAB, 8'h67}, 0);
        chk("e_load_done", 32'(load_done), 32'd1);
        chk("e_insn0_next", 32'(dut.r_mem[0]), 32'hABCD);

        // Length 8193 exceeds the RAM depth.
        do_reset();
        send_seq('{8'hA5, 8'h20, 8'h01}, 0);
        chk("o_rx_ready_err", 32'(rx_ready), 32'd0);
        @(negedge clk);
        chk("o_load_err", 32'(load_err), 32'd1);
        idle(2);
        chk("o_insn0_kept", 32'(insn), 32'hABCD);

        // Inter-byte stall longer than the timeout.
        do_reset();
        send_seq('{8'hA5, 8'h00, 8'h02, 8'h34}, 0);
        idle(18);
        chk("t_load_err", 32'(load_err), 32'd1);
        chk("t_core_reset", 32'(core_reset), 32'd1);

        // Asynchronous reset while waiting for a hi byte.
        code_addr = 13'd1;
        send_seq('{8'hA5, 8'h00, 8'h02, 8'h34}, 0);
        chk("r_insn_before", 32'(insn), 32'h5678);
        #2 resetq = 1'b0;
        #1;
        chk("r_insn", 32'(insn), 32'h0);
        chk("r_core_reset", 32'(core_reset), 32'd1);
        chk("r_load_done", 32'(load_done), 32'd0);
        chk("r_load_err", 32'(load_err), 32'd0);
        chk("r_rx_ready", 32'(rx_ready), 32'd1);
        @(negedge clk);
        #2 resetq = 1'b1;
        @(negedge clk);
        send_seq('{8'h12, 8'h56}, 0);
        idle(2);
        chk("r_held", 32'(core_reset), 32'd1);

        // Four-word image with random gaps; checksum 0x9F.
        do_reset();
        acc0 = n_acc;
        send_seq('{8'hA5, 8'h00, 8'h04, 8'hEF, 8'hBE, 8'hFE, 8'hCA,
                   8'h02, 8'h01, 8'h0D, 8'hF0, 8'h9F}, 2);
        chk("g_accepts", 32'(n_acc - acc0), 32'd12);
        chk("g_load_done", 32'(load_done), 32'd1);
        code_addr = 13'd0; @(negedge clk); @(negedge clk);
        chk("g_w0", 32'(insn), 32'hBEEF);
        code_addr = 13'd1; @(negedge clk);
        chk("g_w1", 32'(insn), 32'hCAFE);
        code_addr = 13'd2; @(negedge clk);
        chk("g_w2", 32'(insn), 32'h0102);
        code_addr = 13'd3; @(negedge clk);
        chk("g_w3", 32'(insn), 32'hF00D);

`ifdef J1_LOADER_RELOAD_EN
        // Live re-download: 00^01^11^22 = 0x32.
        code_addr = 13'd0;
        send(8'h33, 0);
        chk("l_noise", 32'(core_reset), 32'd0);
        send(8'hA5, 0);
        chk("l_core_reset", 32'(core_reset), 32'd1);
        chk("l_load_done", 32'(load_done), 32'd0);
        send_seq('{8'h00, 8'h01, 8'h11, 8'h22, 8'h32}, 1);
        chk("l_done", 32'(load_done), 32'd1);
        @(negedge clk);
        chk("l_insn0", 32'(insn), 32'h2211);
`else
        rx_valid = 1'b1; rx_data = 8'hA5;
        idle(0);
        repeat (3) @(negedge clk);
        chk("n_run_terminal", 32'(core_reset), 32'd0);
        chk("n_run_ready", 32'(rx_ready), 32'd0);
        rx_valid = 1'b0;
`endif
        idle(3);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
